fadd16_resp_buf: RTL and testbench

- Valid-ready shell around the fixed-latency, stall-free fadd16 pipeline.
- Admits operations upstream of fadd16 using credit-based flow control and drives its s0_vld_i.
- Tracks in-flight ops with a latency-matched valid shift register and captures fadd16 results into an in-order FIFO.
- Presents results to the consumer with a finish valid/ready handshake. A result is never dropped, because fadd16 itself cannot be stalled.

---
 rtl/fadd16_resp_buf.sv | 87 ++++++++
 tb/tb_fadd16_resp_buf.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd16_resp_buf.sv
// fadd16_resp_buf: valid-ready shell around the stall-free fadd16 pipeline with credit-based admission and an in-order result FIFO.
// Optional accumulated-flags register enabled by FADD16_RESP_BUF_FFLAGS_ACC_EN.
module fadd16_resp_buf #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid_i,
    output logic                       start_ready_o,
    output logic                       issue_vld_o,
    input  logic [15:0]                fadd_res_i,
    input  logic [4:0]                 fadd_fflags_i,
    output logic                       finish_valid_o,
    input  logic                       finish_ready_i,
    output logic [15:0]                res_o,
    output logic [4:0]                 fflags_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    input  logic                       fflags_clr_i,
    output logic [4:0]                 fflags_acc_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [LATENCY-1:0] pipe;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      used, used_nxt;
    logic [15:0]        mem_res [DEPTH];
    logic [4:0]         mem_flags [DEPTH];
    logic               ready, issue, pop, capture;

    assign issue          = start_valid_i & ready;
    assign issue_vld_o    = issue;
    assign start_ready_o  = ready;
    assign capture        = pipe[LATENCY-1];
    assign finish_valid_o = occupancy_o != '0;
    assign pop            = finish_valid_o & finish_ready_i;
    assign res_o          = mem_res[rd_ptr];
    assign fflags_o       = mem_flags[rd_ptr];
    assign used_nxt       = (issue & ~pop) ? used + CW'(1) :
                            (~issue & pop) ? used - CW'(1) : used;

    // ready is registered so it stays low through reset and has no path from finish_ready_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            used        <= '0;
            ready       <= 1'b0;
            occupancy_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_res[i]   <= '0;
                mem_flags[i] <= '0;
            end
        end else begin
            pipe  <= (pipe << 1) | LATENCY'(issue);
            used  <= used_nxt;
            ready <= used_nxt < CW'(DEPTH);
            if (capture) begin
                mem_res[wr_ptr]   <= fadd_res_i;
                mem_flags[wr_ptr] <= fadd_fflags_i;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            occupancy_o <= (capture & ~pop) ? occupancy_o + CW'(1) :
                           (~capture & pop) ? occupancy_o - CW'(1) : occupancy_o;
        end
    end

`ifdef FADD16_RESP_BUF_FFLAGS_ACC_EN
    // a clear in the same cycle as a pop keeps only the popped flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fflags_acc_o <= '0;
        else if (pop)
            fflags_acc_o <= (fflags_clr_i ? 5'b0 : fflags_acc_o) | fflags_o;
        else if (fflags_clr_i)
            fflags_acc_o <= '0;
    end
`else
    logic unused_clr;
    assign unused_clr   = fflags_clr_i;
    assign fflags_acc_o = '0;
`endif
endmodule

// File: tb/tb_fadd16_resp_buf.sv
// tb_fadd16_resp_buf: table-driven and scoreboard bench for fadd16_resp_buf with a delay-line stand-in for fadd16.
module tb_fadd16_resp_buf;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [4:0]  flags;
    } vec_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start_valid = 0;
    logic        start_ready, issue_vld;
    logic [15:0] fadd_res;
    logic [4:0]  fadd_fflags;
    logic        finish_valid;
    logic        finish_ready = 0;
    logic [15:0] res;
    logic [4:0]  fflags;
    logic [2:0]  occupancy;
    logic        fflags_clr = 0;
    logic [4:0]  fflags_acc;

    logic [15:0] cur_res = 0;
    logic [4:0]  cur_flags = 0;
    logic [LAT-1:0] sv;
    logic [15:0] sr0 = 0, sr1 = 0;
    logic [4:0]  sf0 = 0, sf1 = 0;

    int checks = 0, errors = 0;
    int mused = 0, mocc = 0, tot_push = 0, tot_pop = 0;
    bit mon_en = 0, hold_v = 0;
    logic [15:0] hold_r;
    logic [4:0]  hold_f;
    logic [20:0] q[$];
    vec_t tab[5];

    always #5 clk = ~clk;

    fadd16_resp_buf #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid_i(start_valid), .start_ready_o(start_ready), .issue_vld_o(issue_vld),
        .fadd_res_i(fadd_res), .fadd_fflags_i(fadd_fflags),
        .finish_valid_o(finish_valid), .finish_ready_i(finish_ready),
        .res_o(res), .fflags_o(fflags), .occupancy_o(occupancy),
        .fflags_clr_i(fflags_clr), .fflags_acc_o(fflags_acc)
    );

    // fadd16 stand-in: the operands' precomputed sum travels a LAT-stage delay line; data is never reset
    always @(posedge clk or negedge rst_n)
        if (!rst_n) sv <= '0;
        else sv <= {sv[0], issue_vld};
    always @(posedge clk) begin
        sr0 <= cur_res; sr1 <= sr0;
        sf0 <= cur_flags; sf1 <= sf0;
    end
    assign fadd_res    = sr1;
    assign fadd_fflags = sf1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        logic p;
        p = finish_valid && finish_ready;
        chk("ready_credit", start_ready, mused < DEPTH);
        chk("occupancy", occupancy, mocc);
        chk("finish_valid", finish_valid, mocc != 0);
        checks++;
        assert (!(sv[LAT-1] && occupancy == DEPTH)) else begin
            errors++;
            $display("FAIL capture_full: capture with occupancy %0d", occupancy);
        end
        if (hold_v) begin
            chk("hold_res", res, hold_r);
            chk("hold_flags", fflags, hold_f);
        end
        hold_v = finish_valid && !finish_ready;
        hold_r = res;
        hold_f = fflags;
        if (p) begin
            tot_pop++;
            if (q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_pop: got %0h/%0h expected none", res, fflags);
            end else chk("pop_data", {res, fflags}, q.pop_front());
        end
        if (issue_vld) begin
            q.push_back({cur_res, cur_flags});
            tot_push++;
        end
        mused += int'(issue_vld) - int'(p);
        mocc  += int'(sv[LAT-1]) - int'(p);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_valid = 0;
        rst_n = 0;
        mon_en = 0;
        hold_v = 0;
        q.delete();
        mused = 0;
        mocc = 0;
        #1;
        chk("rst_ready", start_ready, 0);
        chk("rst_fvalid", finish_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", fflags, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_acc", fflags_acc, 0);
        cyc();
        rst_n = 1;
        @(negedge clk);
        chk("rel_ready_low", start_ready, 0);
        cyc();
        mon_en = 1;
    endtask

    task automatic drain();
        int n;
        start_valid = 0;
        finish_ready = 1;
        n = 0;
        while ((q.size() != 0 || mocc != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
        end
        cyc();
    endtask

    initial begin
        int n, tries, snap;
        tab[0] = '{16'h3C00, 16'h4000, 16'h4200, 5'b00000};
        tab[1] = '{16'h3C00, 16'h3C00, 16'h4000, 5'b00000};
        tab[2] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 5'b00101};
        tab[3] = '{16'h7E00, 16'h3C00, 16'h7E00, 5'b00000};
        tab[4] = '{16'h7C01, 16'h3C00, 16'h7E00, 5'b10000};
        repeat (2) @(posedge clk);
        do_reset();

        // single op: visible only in cycle t+3
        finish_ready = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            start_valid = (i == 0);
            cur_res = tab[0].res;
            cur_flags = tab[0].flags;
            @(negedge clk);
            if (i == 0) chk("single_ready", start_ready, 1);
            chk("single_fvalid", finish_valid, i == 3);
            if (i == 3) chk("single_res", {res, fflags}, {tab[0].res, tab[0].flags});
        end
        cyc();

        // backpressure fill
        finish_ready = 0;
        for (int i = 0; i < 8; i++) begin
            start_valid = 1;
            cur_res = 16'h1000 + 16'(i);
            cur_flags = 0;
            @(negedge clk);
            chk("fill_issue", issue_vld, i < 4);
            chk("fill_ready", start_ready, i < 4);
            if (i == 6) chk("fill_occ", occupancy, 4);
            cyc();
        end
        drain();

        // ordering table, back-to-back with consumer ready
        finish_ready = 1;
        for (int i = 0; i < 8; i++) begin
            start_valid = i < 4;
            cur_res = (i < 4) ? tab[i+1].res : 16'h0;
            cur_flags = (i < 4) ? tab[i+1].flags : 5'h0;
            @(negedge clk);
            chk("order_fvalid", finish_valid, i >= 3 && i <= 6);
            if (i >= 3 && i <= 6)
                chk("order_res", {res, fflags}, {tab[i-2].res, tab[i-2].flags});
            cyc();
        end
`ifdef FADD16_RESP_BUF_FFLAGS_ACC_EN
        chk("acc_value", fflags_acc, 5'b10101);
`else
        chk("acc_tied", fflags_acc, 0);
`endif
        fflags_clr = 1;
        cyc();
        fflags_clr = 0;
        @(negedge clk);
        chk("acc_cleared", fflags_acc, 0);
        cyc();

        // simultaneous issue and pop at used=3
        finish_ready = 0;
        for (int i = 0; i < 3; i++) begin
            start_valid = 1;
            cur_res = 16'h2000 + 16'(i);
            cur_flags = 5'(i);
            cyc();
        end
        start_valid = 0;
        tries = 0;
        while (occupancy != 3 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries == 20) begin
            errors++;
            $display("FAIL used3_setup: occupancy %0d expected 3", occupancy);
        end
        cyc();
        start_valid = 1;
        finish_ready = 1;
        cur_res = 16'h2003;
        @(negedge clk);
        chk("both_issue", issue_vld, 1);
        chk("both_pop", finish_valid, 1);
        cyc();
        finish_ready = 0;
        cur_res = 16'h2004;
        @(negedge clk);
        chk("both_ready_kept", start_ready, 1);
        chk("both_issue2", issue_vld, 1);
        cyc();
        start_valid = 0;
        @(negedge clk);
        chk("full_ready_low", start_ready, 0);
        cyc();
        drain();

        // random stalls
        n = 0;
        tries = 0;
        while (n < 10000 && tries < 60000) begin
            start_valid = ($urandom % 4) != 0;
            finish_ready = ($urandom % 3) != 0;
            cur_res = 16'($urandom);
            cur_flags = 5'($urandom);
            @(negedge clk);
            if (issue_vld) n++;
            tries++;
            cyc();
        end
        chk("rand_issued", n, 10000);
        drain();
        chk("rand_balance", tot_pop, tot_push);

        // reset with 2 in flight and 2 buffered
        finish_ready = 0;
        for (int i = 0; i < 4; i++) begin
            start_valid = 1;
            cur_res = 16'h6000 + 16'(i);
            cur_flags = 5'h1F;
            cyc();
        end
        start_valid = 0;
        chk("pre_rst_occ", occupancy, 2);
        do_reset();
        snap = tot_pop;
        finish_ready = 1;
        start_valid = 1;
        cur_res = 16'h5555;
        cur_flags = 5'h3;
        cyc();
        start_valid = 0;
        repeat (8) cyc();
        drain();
        chk("post_rst_pops", tot_pop - snap, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
